complex_mac_sequencer: RTL and testbench

COMPLEX_MAC_SEQUENCER -- requirements
Module: complex_mac_sequencer

---
 rtl/complex_mac_sequencer.sv | 121 ++++++++++++
 tb/tb_complex_mac_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/complex_mac_sequencer.sv
// Sequences C = A x B through an external complex MAC; results emerge one per N cycles.
// Load/capture events ride a MAC_LATENCY-deep delay line so issue and drain overlap.
module complex_mac_sequencer #(
  parameter int I_DATA_WIDTH = 32,
  parameter int O_DATA_WIDTH = 80,
  parameter int N            = 4,
  parameter int MAC_LATENCY  = 7,
  localparam int AW          = (N * N > 1) ? $clog2(N * N) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [AW-1:0]           a_addr,
  input  logic [I_DATA_WIDTH-1:0] a_rdata,
  output logic [AW-1:0]           b_addr,
  input  logic [I_DATA_WIDTH-1:0] b_rdata,
  output logic [I_DATA_WIDTH-1:0] mac_a,
  output logic [I_DATA_WIDTH-1:0] mac_b,
  output logic                    mac_load,
  input  logic [O_DATA_WIDTH-1:0] mac_acc,
  output logic                    c_valid,
  output logic [AW-1:0]           c_addr,
  output logic [O_DATA_WIDTH-1:0] c_data
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int L  = MAC_LATENCY;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   ci, cj, ck;
  logic            issue, last_issue, last_res, op_vld;
  logic [L-1:0]    ld_pipe;
  logic [L:0]      cap_pipe;
  logic [AW-1:0]   res_cnt;

  assign last_issue = issue && (ci == CW'(N - 1)) && (cj == CW'(N - 1)) && (ck == CW'(N - 1));
  assign last_res   = c_valid && (c_addr == AW'(N * N - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)      state_nxt = ISSUE;
      ISSUE:   if (last_issue) state_nxt = DRAIN;
      DRAIN:   if (last_res)   state_nxt = DONE;
      DONE:                    state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state != IDLE);
    done  = (state == DONE);
    issue = (state == ISSUE);
  end

  // k innermost; counters wrap to zero after the final pair, ready for the next run
  always_ff @(posedge clk) begin
    if (reset) begin
      ci <= '0;
      cj <= '0;
      ck <= '0;
    end else if (issue) begin
      if (ck == CW'(N - 1)) begin
        ck <= '0;
        if (cj == CW'(N - 1)) begin
          cj <= '0;
          ci <= (ci == CW'(N - 1)) ? '0 : ci + 1'b1;
        end else begin
          cj <= cj + 1'b1;
        end
      end else begin
        ck <= ck + 1'b1;
      end
    end
  end

  assign a_addr = issue ? AW'(int'(ci) * N + int'(ck)) : '0;
  assign b_addr = issue ? AW'(int'(ck) * N + int'(cj)) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      op_vld   <= 1'b0;
      ld_pipe  <= '0;
      cap_pipe <= '0;
    end else begin
      op_vld   <= issue;
      ld_pipe  <= {ld_pipe[L-2:0], issue && (ck == '0)};
      cap_pipe <= {cap_pipe[L-1:0], issue && (ck == CW'(N - 1))};
    end
  end

  assign mac_a    = op_vld ? a_rdata : '0;
  assign mac_b    = op_vld ? b_rdata : '0;
  assign mac_load = ld_pipe[L-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      c_valid <= 1'b0;
      c_addr  <= '0;
      c_data  <= '0;
      res_cnt <= '0;
    end else begin
      c_valid <= cap_pipe[L];
      if (cap_pipe[L]) begin
        c_data  <= mac_acc;
        c_addr  <= res_cnt;
        res_cnt <= (res_cnt == AW'(N * N - 1)) ? '0 : res_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_complex_mac_sequencer.sv
// Drives two sequencer instances (N=2/L=7 and N=1/L=2) against memory and MAC models.
module tb_complex_mac_sequencer;
  localparam int N0 = 2, L0 = 7, AW0 = 2;
  localparam int N1 = 1, L1 = 2;

  logic clk, reset;
  int   cyc = 0;
  int   passes = 0, total = 0;

  logic        start, busy, done, mac_load, c_valid;
  logic [AW0-1:0] a_addr, b_addr, c_addr;
  logic [31:0] a_rdata, b_rdata, mac_a, mac_b;
  logic [79:0] mac_acc, c_data;

  logic        start1, busy1, done1, mac_load1, c_valid1;
  logic [0:0]  a_addr1, b_addr1, c_addr1;
  logic [31:0] a_rdata1, b_rdata1, mac_a1, mac_b1;
  logic [79:0] mac_acc1, c_data1;

  logic [31:0] A [0:3];
  logic [31:0] B [0:3];
  logic [31:0] A1, B1;

  complex_mac_sequencer #(.I_DATA_WIDTH(32), .O_DATA_WIDTH(80), .N(N0), .MAC_LATENCY(L0)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .a_addr(a_addr), .a_rdata(a_rdata), .b_addr(b_addr), .b_rdata(b_rdata),
    .mac_a(mac_a), .mac_b(mac_b), .mac_load(mac_load), .mac_acc(mac_acc),
    .c_valid(c_valid), .c_addr(c_addr), .c_data(c_data));

  complex_mac_sequencer #(.I_DATA_WIDTH(32), .O_DATA_WIDTH(80), .N(N1), .MAC_LATENCY(L1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .busy(busy1), .done(done1),
    .a_addr(a_addr1), .a_rdata(a_rdata1), .b_addr(b_addr1), .b_rdata(b_rdata1),
    .mac_a(mac_a1), .mac_b(mac_b1), .mac_load(mac_load1), .mac_acc(mac_acc1),
    .c_valid(c_valid1), .c_addr(c_addr1), .c_data(c_data1));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [79:0] cmul(input logic [31:0] a, input logic [31:0] b);
    logic signed [39:0] ar, ai, br, bi;
    ar = $signed(a[31:16]); ai = $signed(a[15:0]);
    br = $signed(b[31:16]); bi = $signed(b[15:0]);
    return {ar * br - ai * bi, ar * bi + ai * br};
  endfunction

  function automatic logic [79:0] cadd(input logic [79:0] x, input logic [79:0] y);
    return {x[79:40] + y[79:40], x[39:0] + y[39:0]};
  endfunction

  function automatic logic [79:0] widen(input logic [31:0] v);
    logic signed [39:0] r, i;
    r = $signed(v[31:16]); i = $signed(v[15:0]);
    return {r, i};
  endfunction

  // Plain matrix product, entry idx = i*N+j
  function automatic logic [79:0] ref_c(input int idx);
    logic [79:0] acc;
    int i, j;
    i = idx / N0; j = idx % N0; acc = '0;
    for (int k = 0; k < N0; k++) acc = cadd(acc, cmul(A[i*N0+k], B[k*N0+j]));
    return acc;
  endfunction

  // Synchronous-read memories and a complex MAC whose summing stage is L-1 cycles behind its inputs
  logic [79:0] pp [0:L0-2];
  logic [79:0] pp1;
  always @(posedge clk) begin
    a_rdata  <= A[a_addr];
    b_rdata  <= B[b_addr];
    a_rdata1 <= A1;
    b_rdata1 <= B1;
    mac_acc  <= cadd(mac_load ? 80'd0 : mac_acc, pp[L0-2]);
    pp[0]    <= cmul(mac_a, mac_b);
    for (int m = 1; m < L0 - 1; m++) pp[m] <= pp[m-1];
    mac_acc1 <= cadd(mac_load1 ? 80'd0 : mac_acc1, pp1);
    pp1      <= cmul(mac_a1, mac_b1);
  end

  int          cv_cyc[$], ld_cyc[$], dn_cyc[$];
  logic [1:0]  cv_addr[$];
  logic [79:0] cv_dat[$];
  int          bz_cnt;
  int          cv1_cyc[$], dn1_cyc[$];
  logic [79:0] cv1_dat[$];
  logic [0:0]  cv1_addr[$];

  always @(negedge clk) begin
    if (c_valid) begin cv_cyc.push_back(cyc); cv_addr.push_back(c_addr); cv_dat.push_back(c_data); end
    if (done) dn_cyc.push_back(cyc);
    if (mac_load) ld_cyc.push_back(cyc);
    if (busy) bz_cnt++;
    if (c_valid1) begin cv1_cyc.push_back(cyc); cv1_addr.push_back(c_addr1); cv1_dat.push_back(c_data1); end
    if (done1) dn1_cyc.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic clear_rec;
    cv_cyc.delete(); cv_addr.delete(); cv_dat.delete();
    ld_cyc.delete(); dn_cyc.delete(); bz_cnt = 0;
  endtask

  // Pulses start, optionally re-pulses it at s+3, and returns one cycle after done
  task automatic run0(input bit second_start, output int s);
    clear_rec();
    start = 1'b1; s = cyc;
    tick(); start = 1'b0;
    if (second_start) begin
      tick(); tick(); start = 1'b1;
      tick(); start = 1'b0;
    end
    for (int n = 0; n < 300 && !done; n++) tick();
    tick();
  endtask

  task automatic check0(input string t, input int s);
    int nn, base;
    nn = N0 * N0;
    base = s + N0 * N0 * N0 + L0 + 2;
    chk({t, "_nres"}, cv_cyc.size(), nn);
    for (int n = 0; n < nn && n < cv_cyc.size(); n++) begin
      chk({t, "_addr"}, cv_addr[n], n);
      chk({t, "_data"}, cv_dat[n], ref_c(n));
      chk({t, "_vcyc"}, cv_cyc[n], base - (nn - 1 - n) * N0);
    end
    chk({t, "_ndone"}, dn_cyc.size(), 1);
    if (dn_cyc.size() > 0) chk({t, "_dcyc"}, dn_cyc[0], base + 1);
    chk({t, "_nload"}, ld_cyc.size(), nn);
    for (int n = 0; n < nn && n < ld_cyc.size(); n++)
      chk({t, "_lcyc"}, ld_cyc[n], s + 1 + L0 + n * N0);
    chk({t, "_busy"}, bz_cnt, N0 * N0 * N0 + L0 + 3);
  endtask

  initial begin
    int s, s2;
    logic [31:0] bv [0:3];
    start = 1'b0; start1 = 1'b0; reset = 1'b1;
    for (int n = 0; n < 4; n++) begin A[n] = '0; B[n] = '0; end
    A1 = '0; B1 = '0;
    tick(); tick(); reset = 1'b0;

    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_load", mac_load, 0);
    chk("rst_cvld", c_valid, 0);
    chk("rst_maca", mac_a, 0);
    chk("rst_macb", mac_b, 0);
    chk("rst_aaddr", a_addr, 0);
    chk("rst_baddr", b_addr, 0);
    chk("rst_caddr", c_addr, 0);
    chk("rst_cdata", c_data, 0);
    tick();

    // Identity times B reproduces B
    bv[0] = {16'sd1, 16'sd2}; bv[1] = {16'sd3, -16'sd1};
    bv[2] = {-16'sd2, 16'sd0}; bv[3] = {16'sd0, 16'sd5};
    for (int n = 0; n < 4; n++) begin B[n] = bv[n]; A[n] = '0; end
    A[0] = {16'sd1, 16'sd0}; A[3] = {16'sd1, 16'sd0};
    run0(0, s);
    check0("ident", s);
    for (int n = 0; n < 4 && n < cv_dat.size(); n++) chk("ident_eqB", cv_dat[n], widen(bv[n]));

    // All ones-plus-i: every entry is 0+4i
    for (int n = 0; n < 4; n++) begin A[n] = {16'sd1, 16'sd1}; B[n] = {16'sd1, 16'sd1}; end
    run0(0, s);
    check0("ones", s);
    for (int n = 0; n < 4 && n < cv_dat.size(); n++) chk("ones_val", cv_dat[n], {40'd0, 40'd4});
    for (int n = 0; n < 4 && n < ld_cyc.size(); n++) chk("ones_load", ld_cyc[n], s + 8 + 2 * n);

    for (int r = 0; r < 3; r++) begin
      for (int n = 0; n < 4; n++) begin A[n] = $urandom; B[n] = $urandom; end
      run0(0, s);
      check0("rand", s);
    end

    // A start while busy must be ignored
    for (int n = 0; n < 4; n++) begin A[n] = $urandom; B[n] = $urandom; end
    run0(1, s);
    check0("dblstart", s);
    for (int n = 0; n < 20; n++) tick();
    chk("dblstart_quiet", cv_cyc.size() + dn_cyc.size(), 4 + 1);

    // Reset mid-ISSUE kills the computation
    clear_rec();
    start = 1'b1; s = cyc;
    tick(); start = 1'b0;
    while (cyc < s + 6) tick();
    reset = 1'b1;
    tick(); reset = 1'b0;
    chk("midrst_cyc", cyc, s + 7);
    chk("midrst_busy", busy, 0);
    chk("midrst_cvld", c_valid, 0);
    chk("midrst_load", mac_load, 0);
    chk("midrst_maca", mac_a, 0);
    chk("midrst_aaddr", a_addr, 0);
    chk("midrst_done", done, 0);
    for (int n = 0; n < 30; n++) tick();
    chk("midrst_nores", cv_cyc.size(), 0);
    chk("midrst_nodone", dn_cyc.size(), 0);
    run0(0, s);
    check0("afterrst", s);

    // Back-to-back: second start lands the cycle after done
    for (int n = 0; n < 4; n++) begin A[n] = $urandom; B[n] = $urandom; end
    run0(0, s);
    check0("b2b_a", s);
    run0(0, s2);
    chk("b2b_gap", s2, s + N0 * N0 * N0 + L0 + 4);
    check0("b2b_b", s2);

    // N=1, MAC_LATENCY=2 instance
    A1 = {16'sd2, 16'sd3}; B1 = {16'sd4, -16'sd1};
    cv1_cyc.delete(); cv1_addr.delete(); cv1_dat.delete(); dn1_cyc.delete();
    start1 = 1'b1; s = cyc;
    tick(); start1 = 1'b0;
    chk("n1_busy", busy1, 1);
    for (int n = 0; n < 50 && !done1; n++) tick();
    for (int n = 0; n < 5; n++) tick();
    chk("n1_nres", cv1_cyc.size(), 1);
    if (cv1_cyc.size() > 0) begin
      chk("n1_data", cv1_dat[0], {40'd11, 40'd10});
      chk("n1_addr", cv1_addr[0], 0);
      chk("n1_vcyc", cv1_cyc[0], s + 1 + L1 + 2);
    end
    chk("n1_ndone", dn1_cyc.size(), 1);
    if (dn1_cyc.size() > 0) chk("n1_dcyc", dn1_cyc[0], s + 1 + L1 + 3);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
